// File: rtl/bus_arbiter_if.sv
// Master-side channel of bus_arbiter: one transfer request plus its completion pulses.
`timescale 1ns/1ps
interface bus_arbiter_if;
  logic        req;
  logic [29:0] address;
  logic [31:0] data_out;
  logic [3:0]  data_strobes;
  logic        read;
  logic        write;
  logic        ack;
  logic        bus_error;

  modport master (
    output req, address, data_out, data_strobes, read, write,
    input  ack, bus_error
  );

  modport slave (
    input  req, address, data_out, data_strobes, read, write,
    output ack, bus_error
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with hold-limited fairness and memory/display address decode.
// Optional macro BUS_ARBITER_ROUND_ROBIN_EN: simultaneous requests from IDLE favour the master not granted last.
`timescale 1ns/1ps
module bus_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic         clock,
  input  logic         reset,
  bus_arbiter_if.slave m0,
  bus_arbiter_if.slave m1,
  output logic [29:0]  address,
  output logic [31:0]  data_out,
  output logic [3:0]   data_strobes,
  output logic         read,
  output logic         write,
  output logic         memory_cs,
  output logic         display_cs
);

  localparam int               CNT_W   = $clog2(HOLD_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [7:0]       MEM_REGION  = 8'h00;
  localparam logic [7:0]       DISP_REGION = 8'hff;

  typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             grant;
  logic             idle_pick;

  logic [29:0]      addr_q;
  logic [31:0]      data_q;
  logic [3:0]       strb_q;
  logic             rd_q, wr_q, mem_q, disp_q;

  logic [29:0]      sel_addr;
  logic [31:0]      sel_data;
  logic [3:0]       sel_strb;
  logic             sel_rd, sel_wr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  endfunction

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic rr_pref_q;
  assign idle_pick = rr_pref_q;
`else
  assign idle_pick = 1'b0;
`endif

  // State register: owner, hold count and arbitration memory
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      hold_q  <= '0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      rr_pref_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      if (grant) rr_pref_q <= ~owner_d;
`endif
    end
  end

  // Next state and arbitration
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0.req || m1.req) begin
          grant   = 1'b1;
          state_d = BUS;
          owner_d = (m0.req && m1.req) ? idle_pick : m1.req;
          hold_d  = CNT_ONE;
        end
      end
      BUS: state_d = ACK;
      ACK: begin
        if (m0.req || m1.req) begin
          grant   = 1'b1;
          state_d = BUS;
          if (m0.req && m1.req) begin
            // Owner keeps the bus until it has used up its hold budget.
            owner_d = (hold_q >= CNT_MAX) ? ~owner_q : owner_q;
          end else begin
            owner_d = m1.req;
          end
          hold_d = (owner_d == owner_q) ? sat_inc(hold_q) : CNT_ONE;
        end else begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_addr = owner_d ? m1.address      : m0.address;
    sel_data = owner_d ? m1.data_out     : m0.data_out;
    sel_strb = owner_d ? m1.data_strobes : m0.data_strobes;
    sel_rd   = owner_d ? m1.read         : m0.read;
    sel_wr   = owner_d ? m1.write        : m0.write;
  end

  // Transfer capture: granted master's request is registered on entry to BUS
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      mem_q  <= 1'b0;
      disp_q <= 1'b0;
    end else if (grant) begin
      addr_q <= sel_addr;
      data_q <= sel_data;
      strb_q <= sel_strb;
      rd_q   <= sel_rd;
      wr_q   <= sel_wr;
      mem_q  <= (sel_addr[29:22] == MEM_REGION);
      disp_q <= (sel_addr[29:22] == DISP_REGION);
    end
  end

  // Outputs: address/data hold between transfers, strobes only in BUS, completion only in ACK
  always_comb begin
    address      = addr_q;
    data_out     = data_q;
    data_strobes = strb_q;
    read         = 1'b0;
    write        = 1'b0;
    memory_cs    = 1'b0;
    display_cs   = 1'b0;
    m0.ack       = 1'b0;
    m1.ack       = 1'b0;
    m0.bus_error = 1'b0;
    m1.bus_error = 1'b0;
    if (state_q == BUS) begin
      memory_cs  = mem_q;
      display_cs = disp_q;
      read       = rd_q & (mem_q | disp_q);
      write      = wr_q & (mem_q | disp_q);
    end
    if (state_q == ACK) begin
      if (mem_q || disp_q) begin
        m0.ack = ~owner_q;
        m1.ack = owner_q;
      end else begin
        m0.bus_error = ~owner_q;
        m1.bus_error = owner_q;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: per-master stimulus queues, global expected-completion queue.
`timescale 1ns/1ps
module tb_bus_arbiter;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        rd;
    logic        cancel;
  } stim_t;

  typedef struct packed {
    logic        m;
    logic        err;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  ctl;
    logic        chk_lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] bus_address;
  logic [31:0] bus_data_out;
  logic [3:0]  bus_data_strobes;
  logic        bus_read, bus_write, memory_cs, display_cs;

  bus_arbiter_if m0_if();
  bus_arbiter_if m1_if();

  bus_arbiter #(.HOLD_MAX(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .m0           (m0_if),
    .m1           (m1_if),
    .address      (bus_address),
    .data_out     (bus_data_out),
    .data_strobes (bus_data_strobes),
    .read         (bus_read),
    .write        (bus_write),
    .memory_cs    (memory_cs),
    .display_cs   (display_cs)
  );

  always #5 clock = ~clock;

  stim_t st0[$];
  stim_t st1[$];
  exp_t  exp_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    pcyc0 = 0, pcyc1 = 0;
  bit    pres0 = 0, pres1 = 0;
  logic [29:0] last_addr = '0;
  logic [29:0] p_addr;
  logic [31:0] p_data;
  logic [3:0]  p_strb;
  logic [3:0]  p_ctl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic stim_t mkst(input logic [31:0] byte_addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic rd, input logic cancel);
    stim_t s;
    s.addr = byte_addr[31:2];
    s.data = data;
    s.strb = strb;
    s.rd = rd;
    s.cancel = cancel;
    return s;
  endfunction

  function automatic exp_t mk_exp(input logic m, input stim_t s, input logic lat);
    exp_t e;
    logic mem, disp;
    mem  = (s.addr[29:22] == 8'h00);
    disp = (s.addr[29:22] == 8'hff);
    e.m = m;
    e.err = !(mem || disp);
    e.addr = s.addr;
    e.data = s.data;
    e.strb = s.strb;
    e.ctl = {s.rd & !e.err, !s.rd & !e.err, mem, disp};
    e.chk_lat = lat;
    return e;
  endfunction

  // Monitor and master model, all on the falling edge
  initial begin
    exp_t  e;
    stim_t s;
    logic  a0, a1;
    m0_if.req = 0; m0_if.address = '0; m0_if.data_out = '0; m0_if.data_strobes = '0;
    m0_if.read = 0; m0_if.write = 0;
    m1_if.req = 0; m1_if.address = '0; m1_if.data_out = '0; m1_if.data_strobes = '0;
    m1_if.read = 0; m1_if.write = 0;
    forever begin
      @(negedge clock);
      cyc++;
      a0 = m0_if.ack | m0_if.bus_error;
      a1 = m1_if.ack | m1_if.bus_error;
      if (a0 || a1) begin
        chk("one_ack", {a0, a1} == 2'b11, 0);
        if (exp_q.size() == 0) begin
          chk("unexp_ack", {a1, a0}, 0);
        end else begin
          e = exp_q.pop_front();
          last_addr = e.addr;
          chk("ack_master", a1, e.m);
          chk("bus_err", e.m ? m1_if.bus_error : m0_if.bus_error, e.err);
          chk("ack_pulse", e.m ? m1_if.ack : m0_if.ack, !e.err);
          chk("bus_addr", p_addr, e.addr);
          chk("bus_data", p_data, e.data);
          chk("bus_strb", p_strb, e.strb);
          chk("bus_ctl", p_ctl, e.ctl);
          chk("ack_ctl_low", {bus_read, bus_write, memory_cs, display_cs}, 0);
          chk("addr_hold", bus_address, p_addr);
          if (e.chk_lat) chk("latency", cyc - (e.m ? pcyc1 : pcyc0), 2);
        end
        if (a0 && st0.size() != 0) begin void'(st0.pop_front()); pres0 = 0; end
        if (a1 && st1.size() != 0) begin void'(st1.pop_front()); pres1 = 0; end
        if (a0 && st1.size() != 0 && st1[0].cancel) begin void'(st1.pop_front()); pres1 = 0; end
        if (a1 && st0.size() != 0 && st0[0].cancel) begin void'(st0.pop_front()); pres0 = 0; end
      end
      if (st0.size() != 0) begin
        s = st0[0];
        if (!pres0) begin pres0 = 1; pcyc0 = cyc; end
        m0_if.req = 1; m0_if.address = s.addr; m0_if.data_out = s.data;
        m0_if.data_strobes = s.strb; m0_if.read = s.rd; m0_if.write = !s.rd;
      end else begin
        pres0 = 0; m0_if.req = 0; m0_if.read = 0; m0_if.write = 0;
      end
      if (st1.size() != 0) begin
        s = st1[0];
        if (!pres1) begin pres1 = 1; pcyc1 = cyc; end
        m1_if.req = 1; m1_if.address = s.addr; m1_if.data_out = s.data;
        m1_if.data_strobes = s.strb; m1_if.read = s.rd; m1_if.write = !s.rd;
      end else begin
        pres1 = 0; m1_if.req = 0; m1_if.read = 0; m1_if.write = 0;
      end
      p_addr = bus_address;
      p_data = bus_data_out;
      p_strb = bus_data_strobes;
      p_ctl  = {bus_read, bus_write, memory_cs, display_cs};
    end
  end

  task automatic step();
    @(posedge clock);
    #3;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || st0.size() != 0 || st1.size() != 0) && k < budget) begin
      step();
      k++;
    end
    chk("drain_timeout", exp_q.size() + st0.size() + st1.size(), 0);
    exp_q.delete(); st0.delete(); st1.delete();
    repeat (2) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, bus_address, 0);
    chk({tag, "_data"}, bus_data_out, 0);
    chk({tag, "_strb"}, bus_data_strobes, 0);
    chk({tag, "_ctl"}, {bus_read, bus_write, memory_cs, display_cs}, 0);
    chk({tag, "_acks"}, {m0_if.ack, m1_if.ack, m0_if.bus_error, m1_if.bus_error}, 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {bus_read, bus_write, memory_cs, display_cs}, 0);
    chk({tag, "_addr"}, bus_address, last_addr);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    stim_t s0, s1;
    int k;
    #1 reset = 1'b0;
    #1 chk_zero("reset");
    repeat (2) step();
    reset = 1'b1;
    step();

    // Simultaneous requests from IDLE, twice; the loser withdraws when the winner completes
    s0 = mkst(32'h0000_0020, 32'h0, 4'hf, 1'b1, 1'b1);
    s1 = mkst(32'hff00_0020, 32'h0, 4'hf, 1'b1, 1'b1);
    st0.push_back(s0); st1.push_back(s1); exp_q.push_back(mk_exp(1'b0, s0, 1'b1));
    wait_drain(20);
    st0.push_back(s0); st1.push_back(s1);
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    exp_q.push_back(mk_exp(1'b1, s1, 1'b1));
`else
    exp_q.push_back(mk_exp(1'b0, s0, 1'b1));
`endif
    wait_drain(20);

    // Single transfers: memory read, display write, undecoded read
    s0 = mkst(32'h0000_0010, 32'h0, 4'hf, 1'b1, 1'b0);
    st0.push_back(s0); exp_q.push_back(mk_exp(1'b0, s0, 1'b1));
    wait_drain(20);
    chk_idle("idle_030");
    s1 = mkst(32'hff00_0000, 32'h0000_00a5, 4'h1, 1'b0, 1'b0);
    st1.push_back(s1); exp_q.push_back(mk_exp(1'b1, s1, 1'b1));
    wait_drain(20);
    chk_idle("idle_031");
    s0 = mkst(32'h1200_0000, 32'h1234_5678, 4'hc, 1'b1, 1'b0);
    st0.push_back(s0); exp_q.push_back(mk_exp(1'b0, s0, 1'b1));
    wait_drain(20);
    chk_idle("idle_032");

    // Both masters stream continuously: hold limit forces alternation
    do_reset();
    for (int i = 0; i < 9; i++) begin
      st0.push_back(mkst(32'h0000_0100 + 32'(4 * i), 32'h0, 4'hf, 1'b1, 1'b0));
      st1.push_back(mkst(32'hff00_0040 + 32'(4 * i), 32'(i), 4'h3, 1'b0, 1'b0));
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(mk_exp(1'b0, st0[i], 1'b0));
    for (int i = 0; i < 8; i++) exp_q.push_back(mk_exp(1'b1, st1[i], 1'b0));
    exp_q.push_back(mk_exp(1'b0, st0[8], 1'b0));
    exp_q.push_back(mk_exp(1'b1, st1[8], 1'b0));
    wait_drain(80);
    chk_idle("idle_033");

    // Reset asserted while a transfer is on the bus
    st0.push_back(mkst(32'h0000_0200, 32'hdead_beef, 4'hf, 1'b0, 1'b0));
    k = 0;
    while (bus_write !== 1'b1 && k < 10) begin step(); k++; end
    chk("reach_bus", bus_write, 1);
    reset = 1'b0;
    #1 chk_zero("mid_reset");
    st0.delete(); exp_q.delete();
    repeat (3) step();
    reset = 1'b1;
    s1 = mkst(32'h0000_0300, 32'h0, 4'hf, 1'b1, 1'b0);
    st1.push_back(s1); exp_q.push_back(mk_exp(1'b1, s1, 1'b1));
    wait_drain(20);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8: max back-to-back transfers one master may hold the bus while the other requests.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-004 m0_req / m1_req  input  1 each  master requests a transfer; held until its ack or bus_error.
REQ-005 m0_address / m1_address  input  30 each  word address [31:2].
REQ-006 m0_data_out / m1_data_out  input  32 each  write data.
REQ-007 m0_data_strobes / m1_data_strobes  input  4 each  byte lanes.
REQ-008 m0_read, m0_write / m1_read, m1_write  input  1 each  transfer direction; exactly one high while req high.
REQ-009 m0_ack / m1_ack  output  1 each  one-cycle pulse: transfer complete; read data valid on shared data_in this cycle.
REQ-010 m0_bus_error / m1_bus_error  output  1 each  one-cycle pulse: decode failure, replaces ack.
REQ-011 address  output  30  bus word address [31:2].
REQ-012 data_out  output  32  bus write data.
REQ-013 data_strobes  output  4  bus byte lanes.
REQ-014 read / write  output  1 each  bus strobes.
REQ-015 memory_cs / display_cs  output  1 each  decoded selects: address[31:24] = 8'h00 / 8'hff.

Function
REQ-016 States SHALL be IDLE, BUS (drive one granted transfer), ACK (complete it); owner register records granted master.
REQ-017 IDLE: any req -> BUS next edge with owner chosen per REQ-024; no req -> stay IDLE.
REQ-018 BUS: address, data_out, data_strobes, read, write, selects driven from owner's inputs, registered on entry; BUS -> ACK unconditionally.
REQ-019 ACK: bus read/write/selects low; owner's ack pulses (or bus_error per REQ-021); ACK -> BUS if any req pending (arbitrated), else IDLE; one transfer every 2 cycles sustained.
REQ-020 Latency: req sampled high in IDLE at edge N -> BUS at N+1 -> ack at N+2.
REQ-021 address[31:24] neither 8'h00 nor 8'hff: BUS drives no select, read and write held low; ACK pulses owner's bus_error, not ack.
REQ-022 Non-owner ack/bus_error SHALL never assert; both acks never high together.
REQ-023 Idle bus outputs (IDLE, ACK): address, data_out, data_strobes SHALL hold last values; read, write, selects low.
REQ-024 Selection: hold counter counts consecutive transfers by owner; if both request and count < HOLD_MAX, owner keeps bus; at HOLD_MAX, other master granted and count clears; sole requester always granted.
REQ-025 Hold counter width clog2(HOLD_MAX)+1, saturates, clears on owner change or IDLE.
REQ-026 req dropped before ack (protocol violation): transfer in flight completes; ack still pulses.

Reset
REQ-027 reset low SHALL immediately force IDLE, owner = m0, hold counter 0, all outputs 0, regardless of state.
REQ-028 Transfer interrupted by reset SHALL produce no ack/bus_error; first edge after release samples req as in IDLE.

Configuration
REQ-029 Macro BUS_ARBITER_ROUND_ROBIN_EN defined: simultaneous requests from IDLE grant master not granted last; undefined: m0 wins from IDLE; HOLD_MAX rule applies in both.

Verification
REQ-030 m0 read 0x00000010 alone -> read=1, memory_cs=1, address=30'h4 at N+1; m0_ack at N+2; m1_ack never.
REQ-031 m1 write 0xff000000, data 0x000000a5 -> display_cs=1, write=1, data_out=0x000000a5, m1_ack at N+2.
REQ-032 m0 read 0x12000000 -> no select, read=0 in BUS; m0_bus_error pulse at N+2, m0_ack=0.
REQ-033 Both req continuously, HOLD_MAX=8, m0 owner -> 8 m0 acks, then m1 ack, alternation per REQ-024.
REQ-034 reset low during BUS -> outputs 0 within same cycle, no ack; after release with m1_req -> BUS at next edge.
REQ-035 Simultaneous req from IDLE twice: macro defined -> m0 then m1 first grants; undefined -> m0 both.
